// File: rtl/regfile_wb_scheduler_if.sv
// Write-port source bundle: pipeline writeback (A),
// long-latency results (B) and long-latency issue.
interface regfile_wb_scheduler_if;
   logic        a_valid;
   logic [4:0]  a_rw;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rw;
   logic [31:0] b_data;
   logic        iss_valid;
   logic [4:0]  iss_rw;

   modport master (
      output a_valid, a_rw, a_data,
      output b_valid, b_rw, b_data,
      output iss_valid, iss_rw,
      input  b_ready
   );

   modport slave (
      input  a_valid, a_rw, a_data,
      input  b_valid, b_rw, b_data,
      input  iss_valid, iss_rw,
      output b_ready
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between the pipeline and a
// long-latency unit, and scoreboards registers awaiting B results.
module regfile_wb_scheduler #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   regfile_wb_scheduler_if.slave  wb,
   input  logic [4:0]             RA,
   input  logic [4:0]             RB,
   input  logic [4:0]             RD,
   output logic                   hazard,
   output logic                   stall_req,
   output logic                   RegWr,
   output logic [4:0]             RW,
   output logic [31:0]            BusW
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   typedef struct packed {
      logic [4:0]  rw;
      logic [31:0] data;
   } ent_t;

   ent_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   busy;
   logic [SW-1:0] starve;

   logic          a_win;
   logic          nonempty;
   logic          push;
   logic          pop;
   ent_t          head;

   logic          wr_nxt;
   logic [4:0]    rw_nxt;
   logic [31:0]   busw_nxt;
   logic [31:0]   busy_nxt;
   logic [SW-1:0] starve_nxt;
   logic          stall_nxt;
   logic [CW-1:0] count_nxt;

   assign a_win    = wb.a_valid && (wb.a_rw != 5'd0);
   assign nonempty = (count != '0);
   assign wb.b_ready = (count < DEPTH_C);
   assign push     = wb.b_valid && wb.b_ready;
   assign pop      = !a_win && nonempty;
   assign head     = mem[rd_ptr];

   assign hazard = ((RA != 5'd0) && busy[RA])
                 | ((RB != 5'd0) && busy[RB])
                 | ((RD != 5'd0) && busy[RD]);

   always_comb begin
      wr_nxt   = 1'b0;
      rw_nxt   = RW;
      busw_nxt = BusW;
      unique case (1'b1)
         a_win: begin
            wr_nxt   = 1'b1;
            rw_nxt   = wb.a_rw;
            busw_nxt = wb.a_data;
         end
         pop: begin
            wr_nxt   = (head.rw != 5'd0);
            rw_nxt   = head.rw;
            busw_nxt = head.data;
         end
         default: ;
      endcase
   end

   always_comb begin
      count_nxt = count;
      unique case (1'b1)
         push && !pop: count_nxt = count + 1'b1;
         pop && !push: count_nxt = count - 1'b1;
         default: ;
      endcase
   end

   // issue is applied after the pop clear so a same-cycle set wins
   always_comb begin
      busy_nxt = busy;
      if (pop && (head.rw != 5'd0))
         busy_nxt[head.rw] = 1'b0;
      if (wb.iss_valid && (wb.iss_rw != 5'd0))
         busy_nxt[wb.iss_rw] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      starve_nxt = starve;
      if (pop || !nonempty)
         starve_nxt = '0;
      else if (a_win && (starve != STARVE_C))
         starve_nxt = starve + 1'b1;
   end

   always_comb begin
      stall_nxt = stall_req;
      if (pop)
         stall_nxt = 1'b0;
      else if (starve_nxt == STARVE_C)
         stall_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWr     <= 1'b0;
         RW        <= 5'd0;
         BusW      <= 32'd0;
         stall_req <= 1'b0;
         busy      <= 32'd0;
         starve    <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         RegWr     <= wr_nxt;
         RW        <= rw_nxt;
         BusW      <= busw_nxt;
         stall_req <= stall_nxt;
         busy      <= busy_nxt;
         starve    <= starve_nxt;
         count     <= count_nxt;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage needs no reset: the count alone decides validity
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{rw: wb.b_rw, data: wb.b_data};
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Vector table plus write scoreboard for the write-port scheduler.
module tb_regfile_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  RA, RB, RD;
   logic        hazard, stall_req, RegWr;
   logic [4:0]  RW;
   logic [31:0] BusW;

   regfile_wb_scheduler_if wbi ();

   regfile_wb_scheduler #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb        (wbi.slave),
      .RA        (RA),
      .RB        (RB),
      .RD        (RD),
      .hazard    (hazard),
      .stall_req (stall_req),
      .RegWr     (RegWr),
      .RW        (RW),
      .BusW      (BusW)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [4:0]  arw;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  brw;
      logic [31:0] bd;
      logic        iv;
      logic [4:0]  irw;
      logic [4:0]  ra, rb, rd;
      logic        rdy, haz, wr, stl;
   } vec_t;

   typedef struct {
      logic [4:0]  rw;
      logic [31:0] d;
   } wr_t;

   vec_t tbl [$];
   wr_t  a_q [$];
   wr_t  b_q [$];
   int   nvec = 0;
   int   nbad = 0;

   function automatic vec_t mk(
      input logic av, input logic [4:0] arw, input logic [31:0] ad,
      input logic bv, input logic [4:0] brw, input logic [31:0] bd,
      input logic iv, input logic [4:0] irw,
      input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
      input logic rdy, input logic haz, input logic wr, input logic stl);
      vec_t v;
      v.av = av;  v.arw = arw; v.ad = ad;
      v.bv = bv;  v.brw = brw; v.bd = bd;
      v.iv = iv;  v.irw = irw;
      v.ra = ra;  v.rb = rb;   v.rd = rd;
      v.rdy = rdy; v.haz = haz; v.wr = wr; v.stl = stl;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      wbi.a_valid = 0; wbi.a_rw = 0; wbi.a_data = 0;
      wbi.b_valid = 0; wbi.b_rw = 0; wbi.b_data = 0;
      wbi.iss_valid = 0; wbi.iss_rw = 0;
      RA = 0; RB = 0; RD = 0;
   endtask

   task automatic step(input vec_t v, input string tag);
      wr_t e;
      bit  have;
      bit  a_take;
      int  bcnt;
      @(negedge clk);
      wbi.a_valid = v.av; wbi.a_rw = v.arw; wbi.a_data = v.ad;
      wbi.b_valid = v.bv; wbi.b_rw = v.brw; wbi.b_data = v.bd;
      wbi.iss_valid = v.iv; wbi.iss_rw = v.irw;
      RA = v.ra; RB = v.rb; RD = v.rd;
      a_take = v.av && (v.arw != 5'd0);
      bcnt = b_q.size();
      if (a_take) a_q.push_back('{v.arw, v.ad});
      #1;
      chk({tag, " b_ready"}, 32'(wbi.b_ready), 32'(v.rdy));
      chk({tag, " hazard"}, 32'(hazard), 32'(v.haz));
      have = 0;
      if (a_take && a_q.size() > 0) begin
         e = a_q.pop_front(); have = 1;
      end else if (!a_take && bcnt > 0) begin
         e = b_q.pop_front(); have = 1;
      end
      if (v.bv && v.rdy) b_q.push_back('{v.brw, v.bd});
      @(posedge clk);
      #1;
      chk({tag, " RegWr"}, 32'(RegWr), 32'(v.wr));
      chk({tag, " stall_req"}, 32'(stall_req), 32'(v.stl));
      if (have && e.rw != 5'd0) begin
         chk({tag, " RW"}, 32'(RW), 32'(e.rw));
         chk({tag, " BusW"}, BusW, e.d);
      end
   endtask

   initial begin
      idle_in();
      rst_n = 1'b0;

      // A writeback and r0 suppression
      tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(1,0,32'h55,       0,0,0, 0,0, 0,0,0, 1,0,0,0));
      // issue r7, hazard, B result clears it
      tbl.push_back(mk(0,0,0, 0,0,0,          1,7, 0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0,          0,0, 7,0,0, 1,1,0,0));
      tbl.push_back(mk(0,0,0, 1,7,32'h1234,   0,0, 7,0,0, 1,1,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0,          0,0, 7,0,0, 1,1,1,0));
      tbl.push_back(mk(0,0,0, 0,0,0,          0,0, 7,0,0, 1,0,0,0));
      // contention and starvation
      tbl.push_back(mk(1,10,32'hA10, 1,20,32'hB20, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(1,11,32'hA11, 1,21,32'hB21, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(1,12,32'hA12, 1,22,32'hB22, 0,0, 0,0,0, 0,0,1,0));
      tbl.push_back(mk(1,13,32'hA13, 1,22,32'hB22, 0,0, 0,0,0, 0,0,1,0));
      tbl.push_back(mk(1,14,32'hA14, 1,22,32'hB22, 0,0, 0,0,0, 0,0,1,1));
      tbl.push_back(mk(0,0,0,        1,22,32'hB22, 0,0, 0,0,0, 0,0,1,0));
      tbl.push_back(mk(0,0,0,        1,22,32'hB22, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0));
      // same-cycle set/clear of r9, then full FIFO push/pop
      tbl.push_back(mk(0,0,0, 1,9,32'h99,     0,0, 0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0,          1,9, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,0,0, 0,0,0,          0,0, 9,0,0, 1,1,0,0));
      tbl.push_back(mk(1,1,32'h1, 1,24,32'hB24, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(1,2,32'h2, 1,25,32'hB25, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,0,0,     1,26,32'hB26, 0,0, 0,0,0, 0,0,1,0));
      tbl.push_back(mk(0,0,0,     1,26,32'hB26, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,9, 1,1,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,9,0, 1,1,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0));

      repeat (2) @(posedge clk);
      #1;
      chk("rst RegWr", 32'(RegWr), 32'd0);
      chk("rst RW", 32'(RW), 32'd0);
      chk("rst BusW", BusW, 32'd0);
      chk("rst b_ready", 32'(wbi.b_ready), 32'd1);
      chk("rst hazard", 32'(hazard), 32'd0);
      chk("rst stall_req", 32'(stall_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

      // reset mid-operation: two queued B entries and r3 busy
      step(mk(1,4,32'h44, 1,27,32'hB27, 1,3, 0,0,0, 1,0,1,0), "r0");
      step(mk(1,6,32'h66, 1,28,32'hB28, 0,0, 3,0,0, 1,1,1,0), "r1");
      @(negedge clk);
      wbi.a_valid = 1; wbi.a_rw = 8; wbi.a_data = 32'h88;
      wbi.b_valid = 0;
      RA = 3; RD = 9;
      #1;
      chk("pre-rst b_ready", 32'(wbi.b_ready), 32'd0);
      chk("pre-rst hazard", 32'(hazard), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid-rst RegWr", 32'(RegWr), 32'd0);
      chk("mid-rst b_ready", 32'(wbi.b_ready), 32'd1);
      chk("mid-rst hazard", 32'(hazard), 32'd0);
      chk("mid-rst stall_req", 32'(stall_req), 32'd0);
      a_q.delete();
      b_q.delete();
      @(posedge clk);
      @(negedge clk);
      idle_in();
      rst_n = 1'b1;
      step(mk(0,0,0, 0,0,0, 0,0, 3,0,9, 1,0,0,0), "p0");
      step(mk(0,0,0, 0,0,0, 0,0, 3,0,9, 1,0,0,0), "p1");
      step(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0), "p2");
      step(mk(1,12,32'hC0FFEE, 0,0,0, 0,0, 0,0,0, 1,0,1,0), "p3");
      step(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0), "p4");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
